// File: rtl/sort4_job_arbiter.sv
// Round-robin front end that time-shares one combinational 4-lane sorter between
// NREQ requesters, returning each sorted result with its owner's id.
module sort4_job_arbiter #(
   parameter int DW   = 3,
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int LAT  = 2,
   parameter int CW   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*4*DW-1:0] req_data,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [4*DW-1:0]      rsp_data,
   output logic [IDW-1:0]       rsp_id,
   output logic [4*DW-1:0]      srt_inp,
   input  logic [4*DW-1:0]      srt_outp,
   output logic                 busy,
   output logic [CW-1:0]        job_count
);
   localparam int OW   = 4*DW;
   localparam int IW   = $clog2(NREQ);
   localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  id_reg;
   logic [OW-1:0]   op_reg;
   logic [OW-1:0]   res_reg;
   logic [CNTW-1:0] cnt;

   logic            gnt_found;
   logic [IDW-1:0]  gnt_idx;
   logic [IDW-1:0]  gnt_next;
   logic [OW-1:0]   slices [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         slices[i] = req_data[i*OW +: OW];
      end
   end

   // First valid requester at or after ptr, scanning circularly; nothing is latched.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_found && req_valid[IW'((int'(ptr) + k) % NREQ)]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   assign gnt_next = (gnt_idx == LAST_ID) ? '0 : gnt_idx + IDW'(1);

   always_comb begin
      req_ready = '0;
      if (state == IDLE && !rst && gnt_found) begin
         req_ready[IW'(gnt_idx)] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         op_reg    <= '0;
         res_reg   <= '0;
         id_reg    <= '0;
         cnt       <= '0;
         job_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (gnt_found) begin
                  op_reg <= slices[IW'(gnt_idx)];
                  id_reg <= gnt_idx;
                  ptr    <= gnt_next;
                  cnt    <= CNTW'(LAT-1);
                  state  <= WAIT;
               end
            end
            // Sorter is combinational; cnt just lets its output settle for LAT cycles.
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNTW'(1);
               end else begin
                  res_reg <= srt_outp;
                  state   <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  job_count <= job_count + CW'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign rsp_data  = res_reg;
   assign rsp_id    = id_reg;
   assign srt_inp   = op_reg;

endmodule

// File: tb/tb_sort4_job_arbiter.sv
// Bench for sort4_job_arbiter: directed job table, multi-cycle corner sequences and
// a randomized run checked every cycle against a transaction-level model.
module tb_sort4_job_arbiter;
   localparam int DW   = 3;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int LAT  = 2;
   localparam int CW   = 16;
   localparam int OW   = 4*DW;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*OW-1:0]   req_data = '0;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b0;
   logic [OW-1:0]        rsp_data;
   logic [IDW-1:0]       rsp_id;
   logic [OW-1:0]        srt_inp;
   logic [OW-1:0]        srt_outp;
   logic                 busy;
   logic [CW-1:0]        job_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sort4_job_arbiter #(.DW(DW), .NREQ(NREQ), .IDW(IDW), .LAT(LAT), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .srt_inp(srt_inp), .srt_outp(srt_outp),
      .busy(busy), .job_count(job_count)
   );

   // Behavioural sorter: each lane goes to the position given by its rank.
   function automatic logic [OW-1:0] behav_sort(logic [OW-1:0] v);
      logic [OW-1:0] r;
      int pos;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         pos = 0;
         for (int j = 0; j < 4; j++) begin
            if (v[j*DW +: DW] < v[i*DW +: DW] || (v[j*DW +: DW] == v[i*DW +: DW] && j < i)) pos++;
         end
         r[pos*DW +: DW] = v[i*DW +: DW];
      end
      return r;
   endfunction

   assign srt_outp = behav_sort(srt_inp);

   // Reference sort by repeated minimum extraction, smallest into lane 0.
   function automatic logic [OW-1:0] ref_sort(logic [OW-1:0] v);
      int vals[4];
      int best;
      logic [OW-1:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) vals[i] = int'(v[i*DW +: DW]);
      for (int o = 0; o < 4; o++) begin
         best = 0;
         for (int j = 1; j < 4; j++) if (vals[j] < vals[best]) best = j;
         r[o*DW +: DW] = DW'(vals[best]);
         vals[best] = 1000;
      end
      return r;
   endfunction

   function automatic int ref_grant(int p, logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] exp_ready_f(logic r, bit act, int p, logic [NREQ-1:0] v);
      logic [NREQ-1:0] e;
      e = '0;
      if (!r && !act && ref_grant(p, v) >= 0) e[ref_grant(p, v)] = 1'b1;
      return e;
   endfunction

   function automatic logic [OW-1:0] lane_of(logic [NREQ*OW-1:0] d, int i);
      return d[i*OW +: OW];
   endfunction

   function automatic int onehot_idx(logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a job is either absent or "ticks" cycles old.
   bit             chk_en  = 1'b0;
   bit             m_act   = 1'b0;
   int             m_ticks = 0;
   int             m_ptr   = 0;
   logic [OW-1:0]  m_op    = '0;
   logic [OW-1:0]  m_res   = '0;
   logic [IDW-1:0] m_id    = '0;
   logic [CW-1:0]  m_cnt   = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_act <= 1'b0; m_ticks <= 0; m_ptr <= 0;
         m_op <= '0; m_res <= '0; m_id <= '0; m_cnt <= '0;
      end else if (!m_act) begin
         if (ref_grant(m_ptr, req_valid) >= 0) begin
            m_act   <= 1'b1;
            m_ticks <= 0;
            m_op    <= lane_of(req_data, ref_grant(m_ptr, req_valid));
            m_id    <= IDW'(ref_grant(m_ptr, req_valid));
            m_ptr   <= (ref_grant(m_ptr, req_valid) + 1) % NREQ;
         end
      end else if (m_ticks < LAT) begin
         m_ticks <= m_ticks + 1;
         if (m_ticks == LAT-1) m_res <= ref_sort(m_op);
      end else if (rsp_ready) begin
         m_act <= 1'b0;
         m_cnt <= m_cnt + CW'(1);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_req_ready", 64'(req_ready), 64'(exp_ready_f(rst, m_act, m_ptr, req_valid)));
         check("m_rsp_valid", 64'(rsp_valid), 64'(m_act && m_ticks == LAT));
         check("m_busy",      64'(busy),      64'(m_act));
         check("m_srt_inp",   64'(srt_inp),   64'(m_op));
         check("m_rsp_data",  64'(rsp_data),  64'(m_res));
         check("m_rsp_id",    64'(rsp_id),    64'(m_id));
         check("m_job_count", 64'(job_count), 64'(m_cnt));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1;
      req_valid = '0;
      step();
      rst = 1'b0;
   endtask

   // One job from a single requester, starting from IDLE, with rsp_ready high.
   task automatic run_job(input int r, input logic [OW-1:0] d, input logic [OW-1:0] e,
                          input logic [CW-1:0] cnt_exp);
      int n;
      logic [NREQ-1:0] oh;
      step();
      oh = '0;
      oh[r] = 1'b1;
      req_data = NREQ*OW'({$urandom(), $urandom()});
      req_data[r*OW +: OW] = d;
      req_valid = oh;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("job_grant", 64'(req_ready), 64'(oh));
      step();
      req_valid = '0;
      @(negedge clk);
      check("job_srt_inp", 64'(srt_inp), 64'(d));
      n = 0;
      while (!rsp_valid && n < 20) begin
         step();
         n++;
         @(negedge clk);
      end
      check("job_latency", 64'(n), 64'(LAT));
      check("job_rsp_data", 64'(rsp_data), 64'(e));
      check("job_rsp_id", 64'(rsp_id), 64'(r));
      step();
      @(negedge clk);
      check("job_count", 64'(job_count), 64'(cnt_exp));
      check("job_idle", 64'(busy), 64'(0));
   endtask

   typedef struct {
      int            r;
      logic [OW-1:0] d;
      logic [OW-1:0] e;
   } vec_t;

   vec_t tbl[6];
   int   gidx[5];
   int   gcyc[5];

   initial begin
      int n;
      int ng;
      int cyc;

      tbl[0] = '{1, 12'hA7B, 12'hF59};
      tbl[1] = '{3, 12'h000, 12'h000};
      tbl[2] = '{0, 12'hFFF, 12'hFFF};
      tbl[3] = '{2, 12'h053, 12'h688};
      tbl[4] = '{1, 12'hE38, 12'hFC0};
      tbl[5] = '{2, 12'h594, 12'hD12};

      // Reset state, with requests pending while rst is high.
      req_valid = 4'hF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'(0));
      #1;
      rst = 1'b0;
      req_valid = '0;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_job_count", 64'(job_count), 64'(0));
      check("rst_srt_inp", 64'(srt_inp), 64'(0));

      // Directed single jobs.
      do_reset();
      for (int i = 0; i < 6; i++) run_job(tbl[i].r, tbl[i].d, tbl[i].e, CW'(i+1));

      // Round-robin with all requesters valid.
      do_reset();
      req_valid = 4'hF;
      req_data  = NREQ*OW'({$urandom(), $urandom()});
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin gidx[k] = -1; gcyc[k] = -100; end
      ng = 0;
      cyc = 0;
      while (ng < 5 && cyc < 100) begin
         @(negedge clk);
         if (req_ready != '0) begin
            gidx[ng] = onehot_idx(req_ready);
            gcyc[ng] = cyc;
            ng++;
         end
         step();
         cyc++;
      end
      check("rr_count", 64'(ng), 64'(5));
      for (int k = 0; k < 5; k++) check("rr_order", 64'(gidx[k]), 64'(k % NREQ));
      for (int k = 1; k < 5; k++) check("rr_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'(LAT+2));

      // Back-pressure on the response port.
      do_reset();
      step();
      req_data = NREQ*OW'({$urandom(), $urandom()});
      req_data[2*OW +: OW] = 12'h053;
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_grant", 64'(req_ready), 64'(4'b0100));
      step();
      req_valid = 4'hF;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         step();
         n++;
         @(negedge clk);
      end
      check("bp_latency", 64'(n), 64'(LAT));
      for (int k = 0; k < 10; k++) begin
         check("bp_valid", 64'(rsp_valid), 64'(1));
         check("bp_data", 64'(rsp_data), 64'(12'h688));
         check("bp_id", 64'(rsp_id), 64'(2));
         check("bp_req_ready", 64'(req_ready), 64'(0));
         step();
         @(negedge clk);
      end
      step();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_hold_last", 64'(rsp_valid), 64'(1));
      step();
      @(negedge clk);
      check("bp_done_valid", 64'(rsp_valid), 64'(0));
      check("bp_done_count", 64'(job_count), 64'(1));

      // Pointer skip: ptr=2, requesters 0 and 3 valid.
      do_reset();
      run_job(1, 12'h594, 12'hD12, CW'(1));
      step();
      req_valid = 4'b1001;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("skip_first", 64'(req_ready), 64'(4'b1000));
      n = 0;
      do begin
         step();
         n++;
         @(negedge clk);
      end while (req_ready == '0 && n < 20);
      check("skip_second", 64'(req_ready), 64'(4'b0001));
      check("skip_period", 64'(n), 64'(LAT+2));

      // Reset asserted while the job waits on the sorter.
      do_reset();
      run_job(0, 12'hFFF, 12'hFFF, CW'(1));
      step();
      req_data[OW +: OW] = 12'hA7B;
      req_valid = 4'b0010;
      @(negedge clk);
      check("mid_grant", 64'(req_ready), 64'(4'b0010));
      step();
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
      check("mid_busy", 64'(busy), 64'(1));
      step();
      rst = 1'b0;
      @(negedge clk);
      check("mid_busy_clr", 64'(busy), 64'(0));
      check("mid_rsp_valid", 64'(rsp_valid), 64'(0));
      check("mid_job_count", 64'(job_count), 64'(0));
      check("mid_srt_inp", 64'(srt_inp), 64'(0));
      check("mid_rsp_data", 64'(rsp_data), 64'(0));
      run_job(2, 12'h053, 12'h688, CW'(1));

      // Request pulsed and withdrawn while the block is busy.
      do_reset();
      step();
      req_data[OW +: OW] = 12'hA7B;
      req_valid = 4'b0010;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("wd_grant", 64'(req_ready), 64'(4'b0010));
      step();
      req_valid = 4'b0001;
      @(negedge clk);
      check("wd_no_ready", 64'(req_ready), 64'(0));
      step();
      req_valid = '0;
      n = 0;
      @(negedge clk);
      while (busy && n < 20) begin
         step();
         n++;
         @(negedge clk);
      end
      check("wd_idle", 64'(busy), 64'(0));
      check("wd_count", 64'(job_count), 64'(1));
      step();
      req_valid = 4'b0011;
      @(negedge clk);
      check("wd_ptr_kept", 64'(req_ready), 64'(4'b0001));

      // Randomized traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         step();
         req_valid = NREQ'($urandom());
         req_data  = NREQ*OW'({$urandom(), $urandom()});
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 99) == 0);
      end
      step();
      rst = 1'b0;
      req_valid = '0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
